// File: rtl/phoenix_vc_buffer_pkg.sv
// Shared constants, FSM encoding and helpers for the Phoenix VC input buffer.
package phoenix_vc_buffer_pkg;

  localparam int TAM_FLIT       = 16;
  localparam int TAM_BUFFER     = 4;
  localparam int NUM_VC_DEFAULT = 2;

  typedef enum logic {
    REQ_ROUTING = 1'b0,
    SEND_DATA   = 1'b1
  } vc_state_e;

  // Packet position of the flit at the FIFO head; payload saturates.
  typedef enum logic [1:0] {
    IDX_HEADER  = 2'd0,
    IDX_SIZE    = 2'd1,
    IDX_PAYLOAD = 2'd2
  } flit_idx_e;

  function automatic int vc_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phoenix_vc_fifo.sv
// Single-clock per-VC flit FIFO; head is combinational (zero when empty).
// A push into a full FIFO is accepted only when a pull frees a slot in the same cycle.
module phoenix_vc_fifo
  import phoenix_vc_buffer_pkg::*;
#(
  parameter int FLIT_W = TAM_FLIT,
  parameter int DEPTH  = TAM_BUFFER
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pull,
  input  logic [FLIT_W-1:0]        i_tail,
  output logic [FLIT_W-1:0]        o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [FLIT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push;
  logic              do_pull;

  assign o_full  = (cnt_q == CNT_W'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_count = cnt_q;
  assign o_head  = o_empty ? '0 : mem_q[rd_ptr_q];

  assign do_pull = i_pull & ~o_empty;
  assign do_push = i_push & (~o_full | do_pull);

  // Pointers wrap at DEPTH by natural overflow since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_tail;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pull) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pull})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/phoenix_vc_buffer.sv
// Phoenix router input buffer: NUM_VC independent FIFOs, each with its own routing
// request / send FSM and credit line; head-of-FIFO data is combinational to the crossbar.
module phoenix_vc_buffer
  import phoenix_vc_buffer_pkg::*;
#(
  parameter int FLIT_W = TAM_FLIT,
  parameter int DEPTH  = TAM_BUFFER,
  parameter int NUM_VC = NUM_VC_DEFAULT
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_rx,
  input  logic [vc_w(NUM_VC)-1:0]    i_rx_vc,
  input  logic [FLIT_W-1:0]          i_data,
  output logic [NUM_VC-1:0]          o_credit,
  output logic [NUM_VC-1:0]          o_h,
  input  logic [NUM_VC-1:0]          i_ack_h,
  output logic [NUM_VC-1:0]          o_data_av,
  input  logic [NUM_VC-1:0]          i_data_ack,
  output logic [NUM_VC*FLIT_W-1:0]   o_data,
  output logic [NUM_VC-1:0]          o_sender,
  output logic [NUM_VC-1:0]          o_overflow
);

  localparam int VC_W  = vc_w(NUM_VC);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  genvar v;
  generate
    for (v = 0; v < NUM_VC; v++) begin : g_vc
      vc_state_e          state_q, state_d;
      flit_idx_e          idx_q, idx_d;
      logic [FLIT_W-1:0]  rem_q, rem_d;
      logic               sent_q, sent_d;
      logic               ovf_q, ovf_d;

      logic [FLIT_W-1:0]  head;
      logic [CNT_W-1:0]   count;
      logic               fifo_full;
      logic               fifo_empty;
      logic               push;
      logic               pull;
      logic               has_data;
      logic               sending;

      assign push     = i_rx & (i_rx_vc == VC_W'(v));
      assign has_data = ~fifo_empty;
      assign sending  = (state_q == SEND_DATA) & ~sent_q;
      assign pull     = i_data_ack[v] & has_data & sending;

      phoenix_vc_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_pull  (pull),
        .i_tail  (i_data),
        .o_head  (head),
        .o_count (count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
      );

      // Credit also covers the slot being freed this cycle so the upstream can stream at full rate.
      assign o_credit[v]                 = (count != CNT_W'(DEPTH)) | pull;
      assign o_h[v]                      = has_data & ~sending;
      assign o_data_av[v]                = has_data & sending;
      assign o_sender[v]                 = sending;
      assign o_overflow[v]               = ovf_q;
      assign o_data[v*FLIT_W +: FLIT_W]  = head;

      always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        sent_d  = sent_q;
        ovf_d   = ovf_q | (push & fifo_full & ~pull);

        // The cycle after the closing pull is spent clearing the packet context.
        if (sent_q) begin
          state_d = REQ_ROUTING;
          idx_d   = IDX_HEADER;
          rem_d   = '0;
          sent_d  = 1'b0;
        end else begin
          case (state_q)
            REQ_ROUTING: begin
              if (i_ack_h[v]) begin
                state_d = SEND_DATA;
              end
            end
            SEND_DATA: begin
              if (pull) begin
                case (idx_q)
                  IDX_HEADER: begin
                    idx_d = IDX_SIZE;
                  end
                  IDX_SIZE: begin
                    idx_d = IDX_PAYLOAD;
                    rem_d = head;
                    if (head == '0) begin
                      sent_d = 1'b1;
                    end
                  end
                  default: begin
                    rem_d = rem_q - FLIT_W'(1);
                    if (rem_q == FLIT_W'(1)) begin
                      sent_d = 1'b1;
                    end
                  end
                endcase
              end
            end
            default: state_d = REQ_ROUTING;
          endcase
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          state_q <= REQ_ROUTING;
          idx_q   <= IDX_HEADER;
          rem_q   <= '0;
          sent_q  <= 1'b0;
          ovf_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          idx_q   <= idx_d;
          rem_q   <= rem_d;
          sent_q  <= sent_d;
          ovf_q   <= ovf_d;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_phoenix_vc_buffer.sv
// Bench for phoenix_vc_buffer: directed vector table, hand-written corner sequences,
// and randomized traffic checked cycle by cycle against a packet-level queue model.
module tb_phoenix_vc_buffer;

  localparam int FW = 16;
  localparam int D  = 4;
  localparam int NV = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rx = 1'b0;
  logic [0:0]        rx_vc = '0;
  logic [FW-1:0]     din = '0;
  logic [NV-1:0]     ack_h = '0;
  logic [NV-1:0]     data_ack = '0;
  logic [NV-1:0]     credit, h, av, sender, ovf;
  logic [NV*FW-1:0]  dout;

  phoenix_vc_buffer #(.FLIT_W(FW), .DEPTH(D), .NUM_VC(NV)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx),
    .i_rx_vc    (rx_vc),
    .i_data     (din),
    .o_credit   (credit),
    .o_h        (h),
    .i_ack_h    (ack_h),
    .o_data_av  (av),
    .i_data_ack (data_ack),
    .o_data     (dout),
    .o_sender   (sender),
    .o_overflow (ovf)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: buffered flits per VC, grant flag, flits delivered in the
  // current packet, packet length once the size flit has gone, and a done flag
  // for the single clean-up cycle after the last flit.
  logic [FW-1:0] mq [NV][$];
  bit            m_gr   [NV];
  bit            m_done [NV];
  bit            m_ovf  [NV];
  int            m_del  [NV];
  int            m_len  [NV];

  logic [NV-1:0]    e_cr, e_h, e_av, e_snd, e_ovf, e_pull;
  logic [NV*FW-1:0] e_dat;

  logic [FW-1:0] beats [NV][$];
  logic [FW-1:0] gen   [NV][$];

  typedef struct {
    bit            rx;
    int            vc;
    logic [FW-1:0] d;
    logic [NV-1:0] ah;
    logic [NV-1:0] da;
    logic [NV-1:0] cr;
    logic [NV-1:0] h;
    logic [NV-1:0] av;
    logic [NV-1:0] snd;
    logic [FW-1:0] d0;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(bit r, int vc, logic [FW-1:0] d, logic [NV-1:0] ah,
                              logic [NV-1:0] da, logic [NV-1:0] cr, logic [NV-1:0] hh,
                              logic [NV-1:0] a, logic [NV-1:0] s, logic [FW-1:0] d0);
    vec_t t;
    t.rx = r; t.vc = vc; t.d = d; t.ah = ah; t.da = da;
    t.cr = cr; t.h = hh; t.av = a; t.snd = s; t.d0 = d0;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_outs();
    for (int v = 0; v < NV; v++) begin
      bit has;
      bit snd;
      has         = (mq[v].size() != 0);
      snd         = m_gr[v] && !m_done[v];
      e_pull[v]   = data_ack[v] && has && snd;
      e_snd[v]    = snd;
      e_h[v]      = has && !snd;
      e_av[v]     = has && snd;
      e_cr[v]     = (mq[v].size() != D) || e_pull[v];
      e_ovf[v]    = m_ovf[v];
      e_dat[v*FW +: FW] = has ? mq[v][0] : '0;
    end
  endtask

  task automatic model_clock();
    for (int v = 0; v < NV; v++) begin
      bit full;
      if (rst) begin
        mq[v].delete();
        m_gr[v] = 0; m_done[v] = 0; m_ovf[v] = 0; m_del[v] = 0; m_len[v] = 0;
      end else begin
        full = (mq[v].size() == D);
        if (m_done[v]) begin
          m_gr[v] = 0; m_done[v] = 0; m_del[v] = 0; m_len[v] = 0;
        end else if (!m_gr[v]) begin
          if (ack_h[v]) m_gr[v] = 1;
        end else if (e_pull[v]) begin
          m_del[v]++;
          if (m_del[v] == 2) m_len[v] = int'(mq[v][0]) + 2;
          if (m_len[v] != 0 && m_del[v] == m_len[v]) m_done[v] = 1;
        end
        if (e_pull[v]) void'(mq[v].pop_front());
        if (rx && (int'(rx_vc) == v)) begin
          if (!full || e_pull[v]) mq[v].push_back(din);
          else m_ovf[v] = 1;
        end
      end
    end
  endtask

  // Inputs are set at the falling edge; outputs are compared shortly after.
  task automatic cycle();
    #1;
    model_outs();
    if (chk_en) begin
      check("m_credit", credit, e_cr);
      check("m_h", h, e_h);
      check("m_data_av", av, e_av);
      check("m_sender", sender, e_snd);
      check("m_overflow", ovf, e_ovf);
      check("m_data", dout, e_dat);
    end
    for (int v = 0; v < NV; v++)
      if (av[v] && data_ack[v]) beats[v].push_back(dout[v*FW +: FW]);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input int vc, input logic [FW-1:0] d,
                       input logic [NV-1:0] ah, input logic [NV-1:0] da);
    rx = r; rx_vc = vc[0]; din = d; ack_h = ah; data_ack = da;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(0, 0, '0, '0, '0);
      cycle();
    end
  endtask

  task automatic do_reset();
    drive(0, 0, '0, '0, '0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("rst_credit", credit, 2'b11);
    check("rst_h", h, '0);
    check("rst_data_av", av, '0);
    check("rst_sender", sender, '0);
    check("rst_overflow", ovf, '0);
    check("rst_data", dout, '0);
    for (int v = 0; v < NV; v++) beats[v].delete();
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 16'h0011, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 16'h0000);
    tbl[1]  = mk(1, 0, 16'h0002, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 16'h0011);
    tbl[2]  = mk(1, 0, 16'hAAAA, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 16'h0011);
    tbl[3]  = mk(1, 0, 16'hBBBB, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 16'h0011);
    tbl[4]  = mk(0, 0, 16'h0000, 2'b01, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 16'h0011);
    tbl[5]  = mk(0, 0, 16'h0000, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b01, 16'h0011);
    tbl[6]  = mk(0, 0, 16'h0000, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b01, 16'h0002);
    tbl[7]  = mk(0, 0, 16'h0000, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b01, 16'hAAAA);
    tbl[8]  = mk(0, 0, 16'h0000, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b01, 16'hBBBB);
    tbl[9]  = mk(1, 0, 16'h0022, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 16'h0000);
    tbl[10] = mk(1, 0, 16'h0000, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 16'h0022);
    tbl[11] = mk(1, 0, 16'h0033, 2'b01, 2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 16'h0022);
    tbl[12] = mk(0, 0, 16'h0000, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b01, 16'h0022);
    tbl[13] = mk(0, 0, 16'h0000, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b01, 16'h0000);
    tbl[14] = mk(0, 0, 16'h0000, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 16'h0033);
    tbl[15] = mk(0, 0, 16'h0000, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 16'h0033);

    @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    idle(2);

    // Full packet then size-zero packet on VC0
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rx, tbl[i].vc, tbl[i].d, tbl[i].ah, tbl[i].da);
      #1;
      check($sformatf("vec%0d_credit", i), credit, tbl[i].cr);
      check($sformatf("vec%0d_h", i), h, tbl[i].h);
      check($sformatf("vec%0d_data_av", i), av, tbl[i].av);
      check($sformatf("vec%0d_sender", i), sender, tbl[i].snd);
      check($sformatf("vec%0d_data0", i), dout[FW-1:0], tbl[i].d0);
      check($sformatf("vec%0d_overflow", i), ovf, '0);
      cycle();
    end

    // Fill VC1, overflow, then push+pull while full
    do_reset();
    drive(1, 1, 16'h0100, '0, '0); cycle();
    drive(1, 1, 16'h0005, '0, '0); cycle();
    drive(1, 1, 16'h0101, '0, '0); cycle();
    drive(1, 1, 16'h0102, '0, '0); cycle();
    drive(0, 0, '0, '0, '0);
    #1 check("full_credit", credit, 2'b01);
    cycle();
    drive(1, 1, 16'h0103, '0, '0); cycle();
    drive(0, 0, '0, 2'b10, '0);
    #1 check("ovf_set", ovf, 2'b10);
    cycle();
    drive(1, 1, 16'h0104, '0, 2'b10);
    #1;
    check("full_pushpull_credit", credit[1], 1'b1);
    check("full_pushpull_av", av[1], 1'b1);
    check("full_pushpull_head", dout[2*FW-1:FW], 16'h0100);
    cycle();
    drive(0, 0, '0, '0, '0);
    #1;
    check("full_after_credit", credit[1], 1'b0);
    check("full_after_head", dout[2*FW-1:FW], 16'h0005);
    check("ovf_sticky", ovf, 2'b10);
    cycle();

    // VC0 stalled mid-packet while VC1 forwards a whole packet
    do_reset();
    drive(1, 0, 16'h0010, '0, '0);        cycle();
    drive(1, 0, 16'h0003, '0, '0);        cycle();
    drive(1, 0, 16'h0A01, 2'b01, '0);     cycle();
    drive(1, 1, 16'h0020, '0, 2'b01);     cycle();
    drive(1, 1, 16'h0001, '0, 2'b01);     cycle();
    drive(1, 1, 16'h0B01, 2'b10, '0);     cycle();
    repeat (3) begin drive(0, 0, '0, '0, 2'b10); cycle(); end
    drive(1, 0, 16'h0A02, '0, '0);        cycle();
    drive(1, 0, 16'h0A03, '0, '0);        cycle();
    repeat (4) begin drive(0, 0, '0, '0, 2'b01); cycle(); end
    idle(2);
    check("il_vc0_beats", beats[0].size(), 5);
    check("il_vc1_beats", beats[1].size(), 3);
    if (beats[0].size() == 5) begin
      check("il_vc0_b0", beats[0][0], 16'h0010);
      check("il_vc0_b1", beats[0][1], 16'h0003);
      check("il_vc0_b2", beats[0][2], 16'h0A01);
      check("il_vc0_b3", beats[0][3], 16'h0A02);
      check("il_vc0_b4", beats[0][4], 16'h0A03);
    end
    if (beats[1].size() == 3) begin
      check("il_vc1_b0", beats[1][0], 16'h0020);
      check("il_vc1_b1", beats[1][1], 16'h0001);
      check("il_vc1_b2", beats[1][2], 16'h0B01);
    end
    check("il_sender_idle", sender, '0);

    // Starvation inside a packet
    do_reset();
    drive(1, 0, 16'h0040, '0, '0);        cycle();
    drive(1, 0, 16'h0003, 2'b01, '0);     cycle();
    drive(0, 0, '0, '0, 2'b01);           cycle();
    drive(0, 0, '0, '0, 2'b01);           cycle();
    drive(0, 0, '0, '0, 2'b01);
    #1;
    check("starve_av", av[0], 1'b0);
    check("starve_sender", sender[0], 1'b1);
    check("starve_h", h[0], 1'b0);
    cycle();
    drive(0, 0, '0, '0, 2'b01);           cycle();
    drive(1, 0, 16'h0C01, '0, 2'b01);     cycle();
    drive(1, 0, 16'h0C02, '0, 2'b01);     cycle();
    drive(1, 0, 16'h0C03, '0, 2'b01);     cycle();
    drive(0, 0, '0, '0, 2'b01);           cycle();
    drive(0, 0, '0, '0, 2'b01);
    #1 check("starve_done_sender", sender[0], 1'b0);
    cycle();
    idle(1);
    check("starve_beats", beats[0].size(), 5);

    // Reset in the middle of packets with an overflow pending
    do_reset();
    drive(1, 0, 16'h0050, '0, '0);        cycle();
    drive(1, 0, 16'h0004, 2'b01, '0);     cycle();
    drive(1, 0, 16'h0D01, '0, 2'b01);     cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, FW'(16'h0E00 + i), '0, 2'b01);
      cycle();
    end
    do_reset();
    idle(2);

    // Randomized traffic, paced so no flit is dropped
    for (int c = 0; c < 3000; c++) begin
      int            v;
      bit            r;
      logic [FW-1:0] d;
      logic [NV-1:0] da;
      for (int vv = 0; vv < NV; vv++) begin
        if (gen[vv].size() == 0) begin
          int s;
          s = $urandom_range(0, 4);
          gen[vv].push_back(FW'($urandom));
          gen[vv].push_back(FW'(s));
          for (int k = 0; k < s; k++) gen[vv].push_back(FW'($urandom));
        end
      end
      v = $urandom_range(0, NV - 1);
      r = ($urandom_range(0, 3) != 0) && (mq[v].size() < D);
      d = '0;
      if (r) d = gen[v].pop_front();
      for (int k = 0; k < NV; k++) da[k] = ($urandom_range(0, 9) < 7);
      drive(r, v, d, NV'($urandom), da);
      cycle();
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
